// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//
// Owns the single write port of the black-and-white VGA framebuffer. Two
// pixel requesters share it through valid/ready handshakes with round-robin
// arbitration. A built-in clear engine can sweep the whole screen to one
// colour, writing one pixel per clock.
//
// Parameters:
//   WIDTH, HEIGHT   active area; the clear sweeps x 0..WIDTH-1, y 0..HEIGHT-1
//
// Ports:
//   clk50                       framebuffer clock (50 MHz)
//   reset                       synchronous, active-high
//   req{0,1}_valid/x/y/color    requester pixel (x/y are 12-bit signed)
//   req{0,1}_ready              pixel accepted this cycle (combinational)
//   clear_start, clear_color    one-cycle pulse starting a clear; colour sampled with it
//   busy                        clear in progress
//   clear_done                  one-cycle pulse, aligned with the last clear write
//   x, y, pixel_color           framebuffer write data
//   pixel_write                 framebuffer write strobe
//   clip_drop                   (FB_SCHED_CLIP_EN only) an accepted off-screen
//                               pixel was dropped; aligned with where its write would be
//
// Build option FB_SCHED_CLIP_EN: when defined, off-screen requester pixels are
// accepted but not written, and clip_drop reports each one.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrating requesters; clear_start moves to CLEAR
// CLEAR | sweeping the screen, one pixel per clock; requesters stalled

module fb_write_scheduler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic signed [11:0] req0_x,
    input  logic signed [11:0] req0_y,
    input  logic               req0_color,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic signed [11:0] req1_x,
    input  logic signed [11:0] req1_y,
    input  logic               req1_color,
    output logic               req1_ready,
    input  logic               clear_start,
    input  logic               clear_color,
    output logic               busy,
    output logic               clear_done,
    output logic signed [11:0] x,
    output logic signed [11:0] y,
    output logic               pixel_color,
    output logic               pixel_write
`ifdef FB_SCHED_CLIP_EN
    ,
    output logic               clip_drop
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [9:0] CX_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] CY_LAST = 9'(HEIGHT - 1);

    state_t             state_q, state_d;
    logic               last_grant_q;
    logic               clr_color_q;
    logic [9:0]         cx_q;
    logic [8:0]         cy_q;

    logic               gnt0, gnt1;
    logic               accept;
    logic               clear_go;
    logic               clear_last;
    logic signed [11:0] sel_x, sel_y;
    logic               sel_color;
    logic               sel_clip;

    // Next state and grants. Clear has priority over any requester in the
    // cycle it starts; while clearing nobody is granted.
    always_comb begin
        state_d    = state_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        clear_go   = 1'b0;
        clear_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    clear_go = 1'b1;
                    state_d  = CLEAR;
                end else if (req0_valid && req1_valid) begin
                    // Round robin: the side that did not win last time wins now.
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end else begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
            end
            CLEAR: begin
                clear_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);
                if (clear_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    assign sel_x     = gnt1 ? req1_x     : req0_x;
    assign sel_y     = gnt1 ? req1_y     : req0_y;
    assign sel_color = gnt1 ? req1_color : req0_color;

`ifdef FB_SCHED_CLIP_EN
    localparam logic signed [11:0] X_LIM = 12'(WIDTH);
    localparam logic signed [11:0] Y_LIM = 12'(HEIGHT);

    // Sign bit catches negative coordinates; the signed compares catch the far edges.
    assign sel_clip = sel_x[11] | sel_y[11] | (sel_x >= X_LIM) | (sel_y >= Y_LIM);
`else
    assign sel_clip = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            clr_color_q  <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            x            <= '0;
            y            <= '0;
            pixel_color  <= 1'b0;
            pixel_write  <= 1'b0;
            busy         <= 1'b0;
            clear_done   <= 1'b0;
`ifdef FB_SCHED_CLIP_EN
            clip_drop    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pixel_write <= 1'b0;
            clear_done  <= 1'b0;
`ifdef FB_SCHED_CLIP_EN
            clip_drop   <= 1'b0;
`endif
            if (clear_go) begin
                clr_color_q <= clear_color;
                cx_q        <= '0;
                cy_q        <= '0;
                busy        <= 1'b1;
            end else if (state_q == CLEAR) begin
                x           <= {2'b00, cx_q};
                y           <= {3'b000, cy_q};
                pixel_color <= clr_color_q;
                pixel_write <= 1'b1;
                if (clear_last) begin
                    // busy/clear_done change together with the last write
                    // becoming visible; arbitration resumes in that cycle.
                    busy       <= 1'b0;
                    clear_done <= 1'b1;
                    cx_q       <= '0;
                    cy_q       <= '0;
                end else if (cx_q == CX_LAST) begin
                    cx_q <= '0;
                    cy_q <= cy_q + 9'd1;
                end else begin
                    cx_q <= cx_q + 10'd1;
                end
            end else if (accept) begin
                x            <= sel_x;
                y            <= sel_y;
                pixel_color  <= sel_color;
                pixel_write  <= ~sel_clip;
                last_grant_q <= gnt1;
`ifdef FB_SCHED_CLIP_EN
                clip_drop    <= sel_clip;
`endif
            end
        end
    end

endmodule
